// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns single read/write commands on a valid/ready port into
// APB SETUP/ACCESS transfers, one response per command, with a stall timeout.
module apb_cmd_master #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // A disabled timeout still needs a legal 1-bit counter.
  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  // Counter value seen on the last ACCESS cycle allowed before abort.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wcnt, wcnt_nxt;
  logic             accept, done, abort;

  // Byte lanes below the word boundary never reach the bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cmd_addr[1:0];

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;

  // Next-state, wait counter and completion/abort decode.
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    done      = 1'b0;
    abort     = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = SETUP;
          wcnt_nxt  = '0;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (TIMEOUT_CYC > 0 && wcnt == CNT_LAST) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else if (wcnt != '1) begin
          wcnt_nxt = wcnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // Registered APB outputs and response fields; the command is latched on accept
  // so later changes on cmd_* cannot disturb the transfer in flight.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR       <= '0;
      PWDATA      <= '0;
      PWRITE      <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        PADDR  <= {cmd_addr[ADDR_W-1:2], 2'b00};
        PWRITE <= cmd_write;
        PWDATA <= cmd_wdata;
      end
      PSEL      <= (state_nxt != IDLE);
      PENABLE   <= (state_nxt == ACCESS);
      rsp_valid <= done | abort;
      if (done) begin
        rsp_rdata   <= PWRITE ? '0 : PRDATA;
        rsp_err     <= PSLVERR;
        rsp_timeout <= 1'b0;
      end else if (abort) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: drives commands into apb_cmd_master against a register
// slave (DATA 0x0, CONTROL 0x4, RESULT 0x8, 0xC errors) with programmable wait
// states, and compares every response to a transaction-level model.
module tb_apb_cmd_master;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  int n_cmp = 0;
  int n_bad = 0;

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  // ---------------- APB slave (stimulus side) ----------------
  logic [31:0] s_data = '0, s_ctrl = '0, s_res = '0;
  int          slv_waits = 0;
  bit          slv_stuck = 1'b0;
  int          slv_cnt = 0;

  assign PREADY  = !slv_stuck && (slv_cnt >= slv_waits);
  assign PSLVERR = (PADDR[3:2] == 2'b11);
  always_comb begin
    PRDATA = 32'hDEADBEEF;
    case (PADDR[3:2])
      2'b00: PRDATA = s_data;
      2'b01: PRDATA = s_ctrl;
      2'b10: PRDATA = s_res;
      default: PRDATA = 32'hDEADBEEF;
    endcase
  end

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) slv_cnt <= slv_cnt + 1;
    else slv_cnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE) begin
      case (PADDR[3:2])
        2'b00: s_data <= PWDATA;
        2'b01: begin s_ctrl <= PWDATA; if (PWDATA[0]) s_res <= s_data; end
        default: ;
      endcase
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] m_reg [3] = '{32'h0, 32'h0, 32'h0};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One command end to end; waits = PREADY-low ACCESS cycles, stuck = never ready.
  task automatic do_cmd(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input int waits, input bit stuck, output logic [31:0] rd);
    int  eff, lat, n, ps, pe, bad_bus, bad_rdy;
    bit  got, to, eaddr;
    logic [31:0] exp_rd;
    logic [1:0]  idx;
    idx   = a[3:2];
    eaddr = (idx == 2'b11);
    eff   = stuck ? 1000 : waits;
    to    = (eff >= 16);
    lat   = to ? 18 : 3 + eff;
    exp_rd = (to || wr) ? 32'h0 : (eaddr ? 32'hDEADBEEF : m_reg[idx]);

    slv_waits = waits;
    slv_stuck = stuck;
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    @(negedge PCLK);
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
    n = 0; ps = 0; pe = 0; bad_bus = 0; bad_rdy = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      n++;
      if (rsp_valid) got = 1'b1;
      else begin
        if (PSEL) ps++;
        if (PENABLE) pe++;
        if (PADDR !== {a[31:2], 2'b00} || PWRITE !== wr || (wr && PWDATA !== wd)) bad_bus++;
        if (cmd_ready) bad_rdy++;
        @(negedge PCLK);
      end
    end
    chk("rsp_seen", got, 1'b1);
    chk("latency", n, lat);
    chk("psel_cycles", ps, lat - 1);
    chk("penable_cycles", pe, lat - 2);
    chk("bus_stable", bad_bus, 0);
    chk("ready_busy", bad_rdy, 0);
    chk("psel_off", {PSEL, PENABLE}, 2'b00);
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err", rsp_err, to | eaddr);
    chk("rsp_timeout", rsp_timeout, to);
    rd = rsp_rdata;
    if (wr && !to && !eaddr) begin
      if (idx == 2'b00) m_reg[0] = wd;
      else if (idx == 2'b01) begin m_reg[1] = wd; if (wd[0]) m_reg[2] = m_reg[0]; end
    end
    slv_stuck = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int hs, rs, r, w;
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;

    // T1: reset values
    #15;
    chk("rst_apb", {PSEL, PENABLE, PWRITE}, 3'b000);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_ready", cmd_ready, 1'b1);
    @(negedge PCLK); @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    do_cmd(1'b0, 32'h0, 32'h0, 0, 1'b0, rd);
    do_cmd(1'b0, 32'h4, 32'h0, 0, 1'b0, rd);
    do_cmd(1'b0, 32'h8, 32'h0, 0, 1'b0, rd);

    // T2: zero-wait write/write/read
    do_cmd(1'b1, 32'h0, 32'h0000000F, 0, 1'b0, rd);
    do_cmd(1'b1, 32'h4, 32'h1, 0, 1'b0, rd);
    do_cmd(1'b0, 32'h8, 32'h0, 0, 1'b0, rd);
    chk("t2_result", rd, 32'h0000000F);

    // T3: three wait states
    do_cmd(1'b0, 32'h0, 32'h0, 3, 1'b0, rd);
    chk("t3_data", rd, 32'h0000000F);

    // T4: slave error then a clean read
    do_cmd(1'b1, 32'hC, 32'h12345678, 0, 1'b0, rd);
    do_cmd(1'b0, 32'h8, 32'h0, 0, 1'b0, rd);

    // T5: timeout boundary
    do_cmd(1'b0, 32'h0, 32'h0, 0, 1'b1, rd);
    do_cmd(1'b0, 32'h0, 32'h0, 15, 1'b0, rd);
    do_cmd(1'b1, 32'h0, 32'hA5A5A5A5, 16, 1'b0, rd);
    do_cmd(1'b1, 32'h0, 32'h5A5A5A5A, 15, 1'b0, rd);

    // Randomised traffic
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      w = (r < 6) ? $urandom_range(0, 3) : (r < 8) ? $urandom_range(14, 17) : 0;
      do_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, w, (r == 8), rd);
    end

    // T6: async reset mid-ACCESS
    slv_stuck = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("t6_pen_before", PENABLE, 1'b1);
    #2 PRESETn = 1'b0;
    #1;
    chk("t6_async_drop", {PSEL, PENABLE}, 2'b00);
    rs = 0;
    repeat (2) begin @(negedge PCLK); if (rsp_valid) rs++; end
    slv_stuck = 1'b0;
    PRESETn = 1'b1;
    repeat (4) begin @(negedge PCLK); if (rsp_valid) rs++; end
    chk("t6_no_rsp", rs, 0);
    chk("t6_ready", cmd_ready, 1'b1);

    // Back-to-back with cmd_valid held high
    slv_waits = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8;
    hs = 0; rs = 0;
    for (int i = 0; i < 12; i++) begin
      if (cmd_ready) hs++;
      if (rsp_valid) begin rs++; chk("b2b_rdata", rsp_rdata, m_reg[2]); end
      @(negedge PCLK);
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) begin rs++; chk("b2b_rdata", rsp_rdata, m_reg[2]); end
      @(negedge PCLK);
    end
    chk("b2b_accepts", hs, 4);
    chk("b2b_rsps", rs, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
